// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF_ID / ID_EX / EX_MEM / MEM_WB latch chain.
// Latency: stall/flush/pc_write are same-cycle decodes of state+inputs; mem_error/stall_count registered.
// Backpressure: a data-memory wait freezes every latch and the PC until mem_ready or the request drops.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rt, ex_rd/ex_mem_read   load-use hazard detection inputs
//   ex_branch_taken     taken branch/jump resolved in EX
//   mem_req/mem_ready   MEM-stage data-memory handshake
//   pc_write            PC may advance
//   stall_*             hold the named latch
//   flush_if_id/_id_ex  load a bubble into the named latch
//   mem_error           sticky memory-timeout flag
//   stall_count         saturating count of cycles with pc_write=0
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_stall;
    logic            load_use;

    assign mem_stall = mem_req & ~mem_ready;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // Priority: ERR > mem_stall > branch > load-use > none.
    // A branch arriving during a memory wait is simply not acted on; its source
    // keeps it asserted, so it wins on the cycle the wait releases.
    always_comb begin
        pc_write     = 1'b1;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (!rst) begin
            if (state == ERR || mem_stall) begin
                pc_write     = 1'b0;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                stall_mem_wb = 1'b1;
            end else if (ex_branch_taken) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (load_use) begin
                // Hold the dependent instr in ID and feed EX one bubble.
                pc_write     = 1'b0;
                stall_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!pc_write && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
                        state     <= ERR;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int TO    = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             pc_write, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic             flush_if_id, flush_id_ex, mem_error;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // Bench-side reference state: 0=RUN 1=MEM_WAIT 2=ERR
    int m_state = 0;
    int m_wc    = 0;
    int m_err   = 0;
    int m_sc    = 0;

    logic [11:0] sb[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .mem_error(mem_error), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s [%s] got=%h want=%h t=%0t", tag, phase, obs, exp, $time);
        end
    endtask

    // {pc_write, stall if_id/id_ex/ex_mem/mem_wb, flush if_id/id_ex, mem_error, stall_count}
    function automatic logic [11:0] model_out();
        logic       ms, lu;
        logic [6:0] c;
        ms = mem_req && !mem_ready;
        lu = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
        if (rst)               c = 7'b1_0000_00;
        else if (m_state == 2) c = 7'b0_1111_00;
        else if (ms)           c = 7'b0_1111_00;
        else if (ex_branch_taken) c = 7'b1_0000_11;
        else if (lu)           c = 7'b0_1000_01;
        else                   c = 7'b1_0000_00;
        return {c, m_err[0], 4'(m_sc)};
    endfunction

    task automatic model_step(input logic pcw);
        logic ms;
        ms = mem_req && !mem_ready;
        if (rst) begin
            m_state = 0; m_wc = 0; m_err = 0; m_sc = 0;
        end else begin
            if (!pcw && m_sc != 15) m_sc++;
            if (m_state == 0 && ms) begin
                m_state = 1; m_wc = 1;
            end else if (m_state == 1) begin
                if (!ms) begin
                    m_state = 0; m_wc = 0;
                end else if (m_wc == TO - 1) begin
                    m_state = 2; m_err = 1;
                end else begin
                    m_wc++;
                end
            end
        end
    endtask

    // One clock cycle: drive, predict, compare at negedge, advance model at posedge.
    task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic mq, input logic my);
        logic [11:0] exp, obs;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = br; mem_req = mq; mem_ready = my;
        sb.push_back(model_out());
        @(negedge clk);
        obs = {pc_write, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
               flush_if_id, flush_id_ex, mem_error, stall_count};
        exp = sb.pop_front();
        check("outs", 32'(obs), 32'(exp));
        @(posedge clk);
        model_step(exp[11]);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        phase = "reset";
        do_reset();
        check("rst_count", 32'(stall_count), 0);
        check("rst_err", 32'(mem_error), 0);

        phase = "load_use";
        cyc(0, 5, 0, 0, 5, 1, 0, 0, 0);
        idle(1);
        check("lu_count", 32'(stall_count), 1);
        cyc(0, 3, 7, 1, 7, 1, 0, 0, 0);   // match through rt
        cyc(0, 3, 7, 0, 7, 1, 0, 0, 0);   // rt not read: no hazard
        cyc(0, 7, 0, 0, 7, 0, 0, 0, 0);   // not a load: no hazard
        idle(1);

        phase = "mem_wait";
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("mw_count", 32'(stall_count), 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);   // zero-wait access
        idle(1);

        phase = "collision";
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 5, 0, 0, 5, 1, 1, 0, 0);   // branch beats load-use
        idle(1);

        phase = "timeout";
        do_reset();
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("to_err", 32'(mem_error), 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);   // ERR holds regardless of inputs
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("to_sticky", 32'(mem_error), 1);
        do_reset();
        check("to_cleared", 32'(mem_error), 0);
        idle(1);

        phase = "corner";
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);   // load to r0
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 22; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("sat_count", 32'(stall_count), 15);

        phase = "random";
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 30) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
